// File: rtl/apb_event_sink_pkg.sv
// Shared constants, enums and address decode for the APB event-report sink.
package apb_event_sink_pkg;

  localparam logic [15:0] REGION_A    = 16'hABBA;
  localparam logic [15:0] REGION_B    = 16'hBAFF;
  localparam logic [15:0] REGION_C    = 16'hCAFE;
  localparam logic [15:0] REGION_STAT = 16'h5EED;

  localparam logic [15:0] OFF_REG0 = 16'h0000;
  localparam logic [15:0] OFF_REG1 = 16'h0004;

  localparam logic [31:0] BLOCK_ID = 32'h0001_0000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [2:0] {CH_A, CH_B, CH_C, CH_STAT, CH_BAD} chan_t;

  // Unknown region or an offset other than 0x0/0x4 both map to CH_BAD.
  function automatic chan_t decode_chan(input logic [31:0] addr);
    chan_t ch;
    case (addr[31:16])
      REGION_A:    ch = CH_A;
      REGION_B:    ch = CH_B;
      REGION_C:    ch = CH_C;
      REGION_STAT: ch = CH_STAT;
      default:     ch = CH_BAD;
    endcase
    if (addr[15:0] != OFF_REG0 && addr[15:0] != OFF_REG1) ch = CH_BAD;
    return ch;
  endfunction

endpackage

// File: rtl/apb_event_sink_if.sv
// APB completer-side bus bundle for apb_event_sink.
// Handshake: a transfer completes in the one cycle where psel & penable & pready are all high;
// prdata/pslverr are meaningful only in that cycle.
interface apb_event_sink_if;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (output psel, penable, paddr, pwrite, pwdata,
                  input  pready, prdata, pslverr);
  modport slave  (input  psel, penable, paddr, pwrite, pwdata,
                  output pready, prdata, pslverr);
endinterface

// File: rtl/apb_event_sink_sat_accum.sv
// 32-bit running total that clamps at SAT_MAX; sat_o flags an add that would exceed it.
module apb_event_sink_sat_accum #(
  parameter logic [31:0] SAT_MAX = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        add_en_i,
  input  logic [31:0] add_val_i,
  output logic [31:0] total_o,
  output logic        sat_o
);

  logic [31:0] total_q, total_d;
  logic [32:0] sum;

  assign sum   = {1'b0, total_q} + {1'b0, add_val_i};
  assign sat_o = add_en_i && (sum > {1'b0, SAT_MAX});

  always_comb begin
    total_d = total_q;
    if (add_en_i) total_d = sat_o ? SAT_MAX : sum[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) total_q <= '0;
    else       total_q <= total_d;
  end

  assign total_o = total_q;

endmodule

// File: rtl/apb_event_sink.sv
// APB completer holding last/total event counts for channels A/B/C plus a W1C status register.
// Build option: define APB_EVENT_SINK_PSLVERR_EN to answer bad addresses and RO writes with pslverr.
module apb_event_sink
  import apb_event_sink_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] SAT_MAX     = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                reset,
  apb_event_sink_if.slave     apb,
  output logic [2:0]          upd_o,
  output state_t              state_o
);

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [31:0] last_q [3];
  logic [31:0] total [3];
  logic [2:0]  sat;
  logic [4:0]  flags_q, flags_d;
  logic [2:0]  upd_q;

  logic        access, setup, capture, abort;
  chan_t       ch;
  logic        off_hi, bad_access, commit, stat_we;
  logic [2:0]  ch_we;
  logic [31:0] rdata;

  assign access = apb.psel & apb.penable;
  assign setup  = apb.psel & ~apb.penable;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          capture = 1'b1;
          wcnt_d  = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end else if (access) begin
          abort = 1'b1;
        end
      end
      WAIT: begin
        if (!access) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (!access) abort = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode works on the setup-phase capture, so access-phase bus changes are ignored.
  assign ch         = decode_chan(addr_q);
  assign off_hi     = (addr_q[15:0] == OFF_REG1);
  assign bad_access = (ch == CH_BAD) || (write_q && off_hi);
  assign commit     = (state_q == RESP) && access && write_q && !bad_access;
  assign ch_we      = {ch == CH_C, ch == CH_B, ch == CH_A} & {3{commit}};
  assign stat_we    = commit && (ch == CH_STAT);

  for (genvar g = 0; g < 3; g++) begin : g_acc
    apb_event_sink_sat_accum #(.SAT_MAX(SAT_MAX)) u_acc (
      .clk       (clk),
      .reset     (reset),
      .add_en_i  (ch_we[g]),
      .add_val_i (wdata_q),
      .total_o   (total[g]),
      .sat_o     (sat[g])
    );
  end

  // Hardware set terms are OR'd after the W1C mask so they win a same-cycle clear.
  always_comb begin
    flags_d = flags_q;
    if (stat_we) flags_d = flags_q & ~wdata_q[4:0];
    flags_d = flags_d | {|sat, abort, ch_we};
  end

  always_comb begin
    rdata = '0;
    case (ch)
      CH_A:    rdata = off_hi ? total[0] : last_q[0];
      CH_B:    rdata = off_hi ? total[1] : last_q[1];
      CH_C:    rdata = off_hi ? total[2] : last_q[2];
      CH_STAT: rdata = off_hi ? BLOCK_ID : {27'd0, flags_q};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      flags_q <= '0;
      upd_q   <= '0;
      for (int i = 0; i < 3; i++) last_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      flags_q <= flags_d;
      upd_q   <= ch_we;
      if (capture) begin
        addr_q  <= apb.paddr;
        wdata_q <= apb.pwdata;
        write_q <= apb.pwrite;
      end
      for (int i = 0; i < 3; i++) begin
        if (ch_we[i]) last_q[i] <= wdata_q;
      end
    end
  end

  assign apb.pready = (state_q == RESP) && access;
  assign apb.prdata = (apb.pready && !write_q) ? rdata : '0;
`ifdef APB_EVENT_SINK_PSLVERR_EN
  assign apb.pslverr = apb.pready && bad_access;
`else
  assign apb.pslverr = 1'b0;
`endif
  assign upd_o   = upd_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_apb_event_sink.sv
// Scoreboard bench for apb_event_sink: two instances (WAIT_CYCLES 1 and 3) share one stimulus bus.
module tb_apb_event_sink;
  import apb_event_sink_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, use3 = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;

  apb_event_sink_if bus1 ();
  apb_event_sink_if bus3 ();

  assign bus1.psel    = psel & ~use3;
  assign bus1.penable = penable;
  assign bus1.paddr   = paddr;
  assign bus1.pwrite  = pwrite;
  assign bus1.pwdata  = pwdata;
  assign bus3.psel    = psel & use3;
  assign bus3.penable = penable;
  assign bus3.paddr   = paddr;
  assign bus3.pwrite  = pwrite;
  assign bus3.pwdata  = pwdata;

  logic [2:0] upd1, upd3;
  state_t     st1, st3;

  apb_event_sink #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .apb(bus1), .upd_o(upd1), .state_o(st1));
  apb_event_sink #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .apb(bus3), .upd_o(upd3), .state_o(st3));

  logic        pready_act, pslverr_act;
  logic [31:0] prdata_act;
  logic [2:0]  upd_act;
  assign pready_act  = use3 ? bus3.pready  : bus1.pready;
  assign pslverr_act = use3 ? bus3.pslverr : bus1.pslverr;
  assign prdata_act  = use3 ? bus3.prdata  : bus1.prdata;
  assign upd_act     = use3 ? upd3 : upd1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model, one copy per instance: {upd[2:0], is_read, err, data[31:0]}.
  localparam logic [31:0] SAT = 32'hFFFF_FFFF;
  logic [31:0] m_last  [2][3];
  logic [31:0] m_total [2][3];
  logic [4:0]  m_flags [2];
  logic [36:0] exp_q [$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_flags[d] = '0;
      for (int c = 0; c < 3; c++) begin
        m_last[d][c]  = '0;
        m_total[d][c] = '0;
      end
    end
  endtask

  task automatic model_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            output logic [36:0] entry);
    int d, ch;
    logic [15:0] off;
    logic bad, err;
    logic [31:0] data;
    logic [2:0] upd;
    longint sum;
    d = use3 ? 1 : 0;
    off = addr[15:0];
    case (addr[31:16])
      16'hABBA: ch = 0;
      16'hBAFF: ch = 1;
      16'hCAFE: ch = 2;
      16'h5EED: ch = 3;
      default:  ch = 4;
    endcase
    if (off != 16'h0000 && off != 16'h0004) ch = 4;
    bad  = (ch == 4) || (wr && off == 16'h0004);
    err  = 1'b0;
`ifdef APB_EVENT_SINK_PSLVERR_EN
    err  = bad;
`endif
    data = '0;
    upd  = '0;
    if (!wr) begin
      if (ch < 3)       data = (off == 16'h0004) ? m_total[d][ch] : m_last[d][ch];
      else if (ch == 3) data = (off == 16'h0004) ? 32'h0001_0000 : {27'd0, m_flags[d]};
    end else if (!bad) begin
      if (ch < 3) begin
        sum = longint'(m_total[d][ch]) + longint'(wd);
        m_last[d][ch] = wd;
        if (sum > longint'(SAT)) begin
          m_total[d][ch] = SAT;
          m_flags[d][4]  = 1'b1;
        end else begin
          m_total[d][ch] = sum[31:0];
        end
        m_flags[d][ch] = 1'b1;
        upd[ch] = 1'b1;
      end else begin
        m_flags[d] = m_flags[d] & ~wd[4:0];
      end
    end
    entry = {upd, ~wr, err, data};
  endtask

  // Starts and ends #1 after a rising edge; consecutive calls are back-to-back.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    logic [36:0] e;
    int lat;
    bit seen;
    model_xfer(addr, wr, wd, e);
    exp_q.push_back(e);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = $urandom;
    pwdata  = $urandom;
    lat  = 1;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      if (pready_act) seen = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("pready_latency", 32'(lat), use3 ? 32'd5 : 32'd3);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [2:0] pend_upd = '0;
  always @(negedge clk) begin
    logic [36:0] e;
    if (reset) pend_upd = '0;
    else begin
      check("upd_o", 32'(upd_act), 32'(pend_upd));
      pend_upd = '0;
      if (pready_act) begin
        if (exp_q.size() == 0) check("pready_unexpected", 32'(pready_act), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("pslverr", 32'(pslverr_act), 32'(e[32]));
          if (e[33]) check("prdata", prdata_act, e[31:0]);
          pend_upd = e[36:34];
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] region, off;
    logic [31:0] wd;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready1", 32'(bus1.pready), 0);
    check("rst_prdata1", bus1.prdata, 0);
    check("rst_pslverr1", 32'(bus1.pslverr), 0);
    check("rst_upd1", 32'(upd1), 0);
    check("rst_pready3", 32'(bus3.pready), 0);
    check("rst_upd3", 32'(upd3), 0);
    check("rst_state1", 32'(st1), 32'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    apb_xfer(32'hABBA_0000, 1, 32'd5);
    apb_xfer(32'hABBA_0000, 0, 0);
    apb_xfer(32'hABBA_0004, 0, 0);
    apb_xfer(32'h5EED_0000, 1, 32'h1F);
    apb_xfer(32'hBAFF_0000, 1, 32'd3);
    apb_xfer(32'hBAFF_0000, 1, 32'd4);
    apb_xfer(32'hBAFF_0004, 0, 0);
    apb_xfer(32'h5EED_0000, 0, 0);
    apb_xfer(32'h5EED_0000, 1, 32'h2);
    apb_xfer(32'h5EED_0000, 0, 0);
    apb_xfer(32'h5EED_0004, 0, 0);
    apb_xfer(32'hCAFE_0000, 1, 32'hFFFF_FFF0);
    apb_xfer(32'hCAFE_0000, 1, 32'h20);
    apb_xfer(32'hCAFE_0004, 0, 0);
    apb_xfer(32'h5EED_0000, 0, 0);
    apb_xfer(32'hDEAD_0000, 1, 32'd11);
    apb_xfer(32'hABBA_0004, 1, 32'd12);
    apb_xfer(32'hABBA_0008, 1, 32'd13);
    apb_xfer(32'hDEAD_0000, 0, 0);
    apb_xfer(32'hABBA_0000, 0, 0);
    apb_xfer(32'hABBA_0004, 0, 0);

    use3 = 1'b1;
    apb_xfer(32'hCAFE_0000, 1, 32'd9);
    apb_xfer(32'hCAFE_0000, 0, 0);
    apb_xfer(32'hCAFE_0004, 0, 0);
    use3 = 1'b0;

    // Setup then drop psel while the transfer sits in its wait phase.
    psel = 1'b1; penable = 1'b0; paddr = 32'hCAFE_0000; pwrite = 1'b1; pwdata = 32'd123;
    @(posedge clk); #1;
    psel = 1'b0;
    @(posedge clk); #1;
    m_flags[0][3] = 1'b1;
    apb_xfer(32'hCAFE_0000, 0, 0);
    apb_xfer(32'h5EED_0000, 0, 0);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0: region = 16'hABBA;
        1: region = 16'hBAFF;
        2: region = 16'hCAFE;
        3: region = 16'h5EED;
        default: region = 16'hDEAD;
      endcase
      case ($urandom_range(0, 4))
        0, 1: off = 16'h0000;
        2, 3: off = 16'h0004;
        default: off = 16'h0008;
      endcase
      wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      apb_xfer({region, off}, 1'($urandom_range(0, 1)), wd);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Reset while dut1 is in its wait phase.
    psel = 1'b1; penable = 1'b0; paddr = 32'hABBA_0000; pwrite = 1'b1; pwdata = 32'd77;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_pready", 32'(bus1.pready), 0);
    check("midrst_prdata", bus1.prdata, 0);
    check("midrst_pslverr", 32'(bus1.pslverr), 0);
    check("midrst_upd", 32'(upd1), 0);
    check("midrst_state", 32'(st1), 32'(IDLE));
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    apb_xfer(32'hABBA_0000, 0, 0);
    apb_xfer(32'hABBA_0004, 0, 0);
    apb_xfer(32'hCAFE_0004, 0, 0);
    apb_xfer(32'h5EED_0000, 0, 0);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
